// File: rtl/key_schedule_iter_pkg.sv
// Shared AES constants and helpers for the iterative key-schedule engine.
package key_schedule_iter_pkg;

  localparam int WORD_W = 32;
  localparam int RK_W   = 128;

  localparam logic [1:0] KEY_LEN_128 = 2'b00;
  localparam logic [1:0] KEY_LEN_192 = 2'b01;
  localparam logic [1:0] KEY_LEN_256 = 2'b10;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef logic [WORD_W-1:0] word_t;

  // The reserved encoding 11 falls through to the AES-128 values.
  function automatic logic [3:0] getNk(input logic [1:0] keyLen);
    case (keyLen)
      KEY_LEN_192: getNk = 4'd6;
      KEY_LEN_256: getNk = 4'd8;
      default:     getNk = 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] getNr(input logic [1:0] keyLen);
    case (keyLen)
      KEY_LEN_192: getNr = 4'd12;
      KEY_LEN_256: getNr = 4'd14;
      default:     getNr = 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/key_schedule_iter_subbytes.sv
// AES SubBytes over NUMBYTES parallel lanes; each S-box is the GF(2^8)
// inverse (computed as x^254) followed by the AES affine transform.
module key_schedule_iter_subbytes
  import key_schedule_iter_pkg::*;
#(
  parameter int NUMBYTES = 4
) (
  input  logic [8*NUMBYTES-1:0] i_data,
  output logic [8*NUMBYTES-1:0] o_data
);

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    gfMul = p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
    x2   = gfMul(x, x);
    x3   = gfMul(x2, x);
    x6   = gfMul(x3, x3);
    x12  = gfMul(x6, x6);
    x15  = gfMul(x12, x3);
    x30  = gfMul(x15, x15);
    x60  = gfMul(x30, x30);
    x120 = gfMul(x60, x60);
    x240 = gfMul(x120, x120);
    x252 = gfMul(x240, x12);
    inv  = gfMul(x252, x2);
    sbox = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  for (genvar g = 0; g < NUMBYTES; g++) begin : g_lane
    assign o_data[8*g +: 8] = sbox(i_data[8*g +: 8]);
  end

endmodule

// File: rtl/key_schedule_iter.sv
// Iterative AES-128/192/256 key schedule: one 32-bit word per clock,
// round keys streamed over valid/ready with a 4-word collector.
module key_schedule_iter
  import key_schedule_iter_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256,
  parameter int ROUND_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [1:0]              i_key_len,
  input  logic [MAX_KEY_BITS-1:0] i_key_in,
  output logic                    o_busy,
  output logic                    o_rk_valid,
  input  logic                    i_rk_ready,
  output logic [RK_W-1:0]         o_rk_data,
  output logic [ROUND_W-1:0]      o_rk_round,
  output logic                    o_rk_last,
  output logic                    o_done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GEN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]         r_state;
  logic [3:0]         r_nk;
  logic [3:0]         r_nr;
  word_t              r_keyWords [0:7];
  word_t              r_window   [0:7];
  word_t              r_coll     [0:2];
  logic [5:0]         r_wordIdx;
  logic [2:0]         r_modCnt;
  logic [1:0]         r_collCnt;
  logic [ROUND_W-1:0] r_roundCnt;
  logic [7:0]         r_rcon;
  logic               r_rkValid;
  logic [RK_W-1:0]    r_rkData;
  logic [ROUND_W-1:0] r_rkRound;
  logic               r_rkLast;
  logic               r_done;

  logic       w_hs;
  logic       w_collFull;
  logic       w_gen;
  logic       w_isKeyWord;
  logic       w_lastWord;
  logic       w_modWrap;
  logic [2:0] w_backIdx;
  word_t      w_prev;
  word_t      w_back;
  word_t      w_rot;
  word_t      w_subIn;
  word_t      w_sub;
  word_t      w_t;
  word_t      w_new;

  assign w_hs        = r_rkValid & i_rk_ready;
  assign w_collFull  = (r_collCnt == 2'd3);
  // Generation stalls only when the 4th word would have nowhere to go.
  assign w_gen       = (r_state == ST_GEN) && (!w_collFull || !r_rkValid || i_rk_ready);
  assign w_isKeyWord = (r_wordIdx < {2'b00, r_nk});
  assign w_lastWord  = (r_wordIdx == {r_nr, 2'b11});
  assign w_modWrap   = (r_modCnt == 3'(r_nk - 4'd1));
  assign w_backIdx   = 3'(4'd8 - r_nk);
  assign w_prev      = r_window[7];
  assign w_back      = r_window[w_backIdx];
  assign w_rot       = {w_prev[23:0], w_prev[31:24]};
  assign w_subIn     = (r_modCnt == 3'd0) ? w_rot : w_prev;

  key_schedule_iter_subbytes #(
    .NUMBYTES(4)
  ) u_subBytes (
    .i_data(w_subIn),
    .o_data(w_sub)
  );

  always_comb begin
    w_t = w_prev;
    if (r_modCnt == 3'd0) w_t = w_sub ^ {r_rcon, 24'h000000};
    else if (r_nk == 4'd8 && r_modCnt == 3'd4) w_t = w_sub;
    w_new = w_isKeyWord ? r_keyWords[r_wordIdx[2:0]] : (w_back ^ w_t);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_nk       <= 4'd0;
      r_nr       <= 4'd0;
      r_wordIdx  <= 6'd0;
      r_modCnt   <= 3'd0;
      r_collCnt  <= 2'd0;
      r_roundCnt <= '0;
      r_rcon     <= RCON_INIT;
      r_rkValid  <= 1'b0;
      r_rkData   <= '0;
      r_rkRound  <= '0;
      r_rkLast   <= 1'b0;
      r_done     <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        r_keyWords[k] <= '0;
        r_window[k]   <= '0;
      end
      for (int k = 0; k < 3; k++) r_coll[k] <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_hs) r_rkValid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state    <= ST_GEN;
            r_nk       <= getNk(i_key_len);
            r_nr       <= getNr(i_key_len);
            r_wordIdx  <= 6'd0;
            r_modCnt   <= 3'd0;
            r_collCnt  <= 2'd0;
            r_roundCnt <= '0;
            r_rcon     <= RCON_INIT;
            for (int k = 0; k < 8; k++)
              r_keyWords[k] <= i_key_in[MAX_KEY_BITS-1-32*k -: 32];
          end
        end
        ST_GEN: begin
          if (w_gen) begin
            for (int k = 0; k < 7; k++) r_window[k] <= r_window[k+1];
            r_window[7] <= w_new;
            r_coll[0]   <= r_coll[1];
            r_coll[1]   <= r_coll[2];
            r_coll[2]   <= w_new;
            r_wordIdx   <= r_wordIdx + 6'd1;
            r_modCnt    <= w_modWrap ? 3'd0 : r_modCnt + 3'd1;
            if (!w_isKeyWord && r_modCnt == 3'd0) r_rcon <= xtime(r_rcon);
            if (w_collFull) begin
              r_rkValid  <= 1'b1;
              r_rkData   <= {r_coll[0], r_coll[1], r_coll[2], w_new};
              r_rkRound  <= r_roundCnt;
              r_rkLast   <= (r_roundCnt == ROUND_W'(r_nr));
              r_roundCnt <= r_roundCnt + ROUND_W'(1);
              r_collCnt  <= 2'd0;
            end else begin
              r_collCnt  <= r_collCnt + 2'd1;
            end
            if (w_lastWord) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_hs && r_rkLast) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy     = (r_state != ST_IDLE);
  assign o_rk_valid = r_rkValid;
  assign o_rk_data  = r_rkData;
  assign o_rk_round = r_rkRound;
  assign o_rk_last  = r_rkLast;
  assign o_done     = r_done;

endmodule

// File: tb/tb_key_schedule_iter.sv
// Directed bench for key_schedule_iter using FIPS-197 key-expansion vectors.
module tb_key_schedule_iter;

  localparam logic [255:0] K128  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K128X = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                                    128'hdeadbeef0123456789abcdeffeedface};
  localparam logic [255:0] K192  = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KOTHER = {8{32'h5a5a0ff0}};

  logic         clk;
  logic         rst_n;
  logic         i_start;
  logic [1:0]   i_key_len;
  logic [255:0] i_key_in;
  logic         o_busy;
  logic         o_rk_valid;
  logic         i_rk_ready;
  logic [127:0] o_rk_data;
  logic [3:0]   o_rk_round;
  logic         o_rk_last;
  logic         o_done;

  key_schedule_iter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_key_len  (i_key_len),
    .i_key_in   (i_key_in),
    .o_busy     (o_busy),
    .o_rk_valid (o_rk_valid),
    .i_rk_ready (i_rk_ready),
    .o_rk_data  (o_rk_data),
    .o_rk_round (o_rk_round),
    .o_rk_last  (o_rk_last),
    .o_done     (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun;
  int testsFailed;

  logic [127:0] gotData [0:15];
  logic         gotLast [0:15];
  int           hsCount, lastHsCyc, firstValidCyc, doneCyc, doneCount;
  int           stallErrs, orderErrs, lastCount;
  logic         busyAtDone;
  logic         timedOut;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Runs one job; with abortRound >= 0 it asserts reset while that round is
  // presented and checks the outputs collapse to zero.
  task automatic applyStimulus(input logic [1:0] keyLen, input logic [255:0] key,
                               input int randomReady, input int injectCycle,
                               input int abortRound, input int expectNr);
    logic         prevStall, readyNow, finished;
    logic [127:0] snapData;
    logic [3:0]   snapRound;
    logic         snapLast;
    prevStall = 1'b0; finished = 1'b0;
    snapData = '0; snapRound = '0; snapLast = 1'b0;
    hsCount = 0; lastHsCyc = -1; firstValidCyc = -1; doneCyc = -1; doneCount = 0;
    stallErrs = 0; orderErrs = 0; lastCount = 0; busyAtDone = 1'b1;
    for (int k = 0; k < 16; k++) begin gotData[k] = '0; gotLast[k] = 1'b0; end

    @(negedge clk);
    i_key_len = keyLen; i_key_in = key; i_start = 1'b1; i_rk_ready = 1'b0;
    @(posedge clk);
    #1;
    i_start = 1'b0; i_key_in = {8{32'hc3c3a5a5}}; i_key_len = 2'b01;

    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      @(negedge clk);
      i_start = (cyc == injectCycle);
      if (cyc == injectCycle) i_key_in = KOTHER;
      if (prevStall && (!o_rk_valid || o_rk_data !== snapData ||
                        o_rk_round !== snapRound || o_rk_last !== snapLast))
        stallErrs++;
      if (o_rk_valid && firstValidCyc < 0) firstValidCyc = cyc;
      if (o_done) begin doneCount++; doneCyc = cyc; busyAtDone = o_busy; end
      if (abortRound >= 0 && o_rk_valid && o_rk_round == 4'(abortRound)) begin
        i_rk_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_valid", 128'(o_rk_valid), 128'd0);
        checkOutput("abort_busy",  128'(o_busy),     128'd0);
        checkOutput("abort_data",  o_rk_data,        128'd0);
        checkOutput("abort_round", 128'(o_rk_round), 128'd0);
        checkOutput("abort_done",  128'(o_done),     128'd0);
        finished = 1'b1;
      end else begin
        readyNow = randomReady != 0 ? ($urandom_range(0, 1) != 0) : 1'b1;
        i_rk_ready = readyNow;
        if (o_rk_valid && readyNow) begin
          if (hsCount < 16) begin
            gotData[hsCount] = o_rk_data;
            gotLast[hsCount] = o_rk_last;
          end
          if (o_rk_round !== 4'(hsCount)) orderErrs++;
          if (o_rk_last) begin lastCount++; lastHsCyc = cyc; end
          hsCount++;
        end
        prevStall = o_rk_valid && !readyNow;
        snapData = o_rk_data; snapRound = o_rk_round; snapLast = o_rk_last;
        if (lastHsCyc >= 0 && cyc == lastHsCyc + 2) finished = 1'b1;
      end
    end
    i_start = 1'b0;
    i_rk_ready = 1'b0;
    timedOut = !finished;

    if (abortRound < 0) begin
      checkOutput("job_timeout",   128'(timedOut),        128'd0);
      checkOutput("hs_count",      128'(hsCount),         128'(expectNr + 1));
      checkOutput("round_order",   128'(orderErrs),       128'd0);
      checkOutput("stall_stable",  128'(stallErrs),       128'd0);
      checkOutput("last_count",    128'(lastCount),       128'd1);
      checkOutput("last_at_nr",    128'(gotLast[expectNr]), 128'd1);
      checkOutput("done_count",    128'(doneCount),       128'd1);
      checkOutput("done_timing",   128'(doneCyc),         128'(lastHsCyc + 1));
      checkOutput("busy_at_done",  128'(busyAtDone),      128'd0);
    end
  endtask

  initial begin
    testsRun = 0; testsFailed = 0;
    rst_n = 1'b0; i_start = 1'b0; i_key_len = 2'b00; i_key_in = '0; i_rk_ready = 1'b0;
    #12;
    checkOutput("reset_valid", 128'(o_rk_valid), 128'd0);
    checkOutput("reset_busy",  128'(o_busy),     128'd0);
    checkOutput("reset_data",  o_rk_data,        128'd0);
    checkOutput("reset_round", 128'(o_rk_round), 128'd0);
    checkOutput("reset_last",  128'(o_rk_last),  128'd0);
    checkOutput("reset_done",  128'(o_done),     128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] AES-128, ready held high");
    applyStimulus(2'b00, K128, 0, -1, -1, 10);
    checkOutput("a128_first_valid", 128'(firstValidCyc), 128'd4);
    checkOutput("a128_final_hs",    128'(lastHsCyc),     128'd44);
    checkOutput("a128_rk0",  gotData[0],  128'h2b7e151628aed2a6abf7158809cf4f3c);
    checkOutput("a128_rk1",  gotData[1],  128'ha0fafe1788542cb123a339392a6c7605);
    checkOutput("a128_rk2",  gotData[2],  128'hf2c295f27a96b9435935807a7359f67f);
    checkOutput("a128_rk10", gotData[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("[TB] AES-192, ready held high");
    applyStimulus(2'b01, K192, 0, -1, -1, 12);
    checkOutput("a192_rk0",  gotData[0],  128'h8e73b0f7da0e6452c810f32b809079e5);
    checkOutput("a192_rk12", gotData[12], 128'he98ba06f448c773c8ecc720401002202);

    $display("[TB] AES-256, ready held high");
    applyStimulus(2'b10, K256, 0, -1, -1, 14);
    checkOutput("a256_final_hs", 128'(lastHsCyc), 128'd60);
    checkOutput("a256_rk1",  gotData[1],  128'h1f352c073b6108d72d9810a30914dff4);
    checkOutput("a256_rk14", gotData[14], 128'hfe4890d1e6188d0b046df344706c631e);

    $display("[TB] AES-256, random ready, start pulsed mid-job");
    applyStimulus(2'b10, K256, 1, 10, -1, 14);
    checkOutput("a256r_rk0",  gotData[0],  128'h603deb1015ca71be2b73aef0857d7781);
    checkOutput("a256r_rk1",  gotData[1],  128'h1f352c073b6108d72d9810a30914dff4);
    checkOutput("a256r_rk2",  gotData[2],  128'h9ba354118e6925afa51a8b5f2067fcde);
    checkOutput("a256r_rk14", gotData[14], 128'hfe4890d1e6188d0b046df344706c631e);

    $display("[TB] key_len 11 treated as AES-128");
    applyStimulus(2'b11, K128X, 0, -1, -1, 10);
    checkOutput("len11_rk1",  gotData[1],  128'ha0fafe1788542cb123a339392a6c7605);
    checkOutput("len11_rk10", gotData[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("[TB] reset during round 5, then restart");
    applyStimulus(2'b00, K128, 0, -1, 5, 10);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'b00, K128, 0, -1, -1, 10);
    checkOutput("rerun_rk0",  gotData[0],  128'h2b7e151628aed2a6abf7158809cf4f3c);
    checkOutput("rerun_rk1",  gotData[1],  128'ha0fafe1788542cb123a339392a6c7605);
    checkOutput("rerun_rk10", gotData[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
